// File: rtl/img_stream_source_if.sv
// Bundle of the frame source's control, pixel-RAM read port and video output.
// The source drives the read strobe/address and the video/status signals.
// The consumer side drives start/continuous and returns RAM data.
interface img_stream_source_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 16
);
   logic                  i_start;
   logic                  i_continuous;
   logic                  o_rd_en;
   logic [ADDR_WIDTH-1:0] o_rd_addr;
   logic [DATA_WIDTH-1:0] i_rd_data;
   logic                  o_v_sync;
   logic                  o_h_sync;
   logic [DATA_WIDTH-1:0] o_img_data;
   logic                  o_busy;
   logic                  o_frame_done;

   modport master (
      input  i_start, i_continuous, i_rd_data,
      output o_rd_en, o_rd_addr, o_v_sync, o_h_sync, o_img_data, o_busy, o_frame_done
   );

   modport slave (
      output i_start, i_continuous, i_rd_data,
      input  o_rd_en, o_rd_addr, o_v_sync, o_h_sync, o_img_data, o_busy, o_frame_done
   );
endinterface

// File: rtl/img_stream_source.sv
// Plays a stored frame from a sync-read pixel RAM as a v_sync/h_sync/pixel stream.
// Latency: o_h_sync/o_v_sync/o_img_data trail the FSM read strobe by 2 cycles.
// No backpressure: the stream runs free once started; start is ignored while busy.
module img_stream_source #(
   parameter int P_DATA_WIDTH = 8,
   parameter int P_IMG_WIDTH  = 256,
   parameter int P_IMG_HEIGHT = 256,
   parameter int P_ADDR_WIDTH = 16,
   parameter int P_H_BLANK    = 16,
   parameter int P_V_PORCH    = 4,
   parameter int P_V_BLANK    = 64
) (
   input logic               i_clk,
   input logic               i_rst,
   img_stream_source_if.master bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      V_LEAD  = 3'd1,
      LINE    = 3'd2,
      H_BLANK = 3'd3,
      V_TAIL  = 3'd4,
      V_BLANK = 3'd5
   } state_t;

   // One shared phase counter times every porch/blanking interval.
   localparam int PH_MAX0 = (P_V_PORCH > P_H_BLANK) ? P_V_PORCH : P_H_BLANK;
   localparam int PH_MAX  = (PH_MAX0 > P_V_BLANK) ? PH_MAX0 : P_V_BLANK;
   localparam int PH_W    = $clog2(PH_MAX + 1);
   localparam int COL_W   = $clog2(P_IMG_WIDTH);
   localparam int ROW_W   = $clog2(P_IMG_HEIGHT);

   state_t                  state;
   logic [PH_W-1:0]         phase;
   logic [COL_W-1:0]        col;
   logic [ROW_W-1:0]        row;
   logic [P_ADDR_WIDTH-1:0] addr;
   logic                    rd_en;
   logic                    v_fsm;
   logic                    busy;

   logic                    v_s1, h_s1, v_s2, h_s2;
   logic [P_DATA_WIDTH-1:0] img_q;
   logic                    done_q;

   // Frame sequencer; read strobe, v_sync and busy are registered alongside the state.
   // The address only advances between consecutive reads so it holds during blanking.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
         phase <= '0;
         col   <= '0;
         row   <= '0;
         addr  <= '0;
         rd_en <= 1'b0;
         v_fsm <= 1'b0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               phase <= '0;
               col   <= '0;
               row   <= '0;
               addr  <= '0;
               rd_en <= 1'b0;
               v_fsm <= 1'b0;
               busy  <= 1'b0;
               if (bus.i_start) begin
                  state <= V_LEAD;
                  v_fsm <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            V_LEAD: begin
               if (phase == PH_W'(P_V_PORCH - 1)) begin
                  phase <= '0;
                  rd_en <= 1'b1;
                  state <= LINE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            LINE: begin
               if (col == COL_W'(P_IMG_WIDTH - 1)) begin
                  col   <= '0;
                  rd_en <= 1'b0;
                  state <= (row == ROW_W'(P_IMG_HEIGHT - 1)) ? V_TAIL : H_BLANK;
               end else begin
                  col  <= col + COL_W'(1);
                  addr <= addr + P_ADDR_WIDTH'(1);
               end
            end
            H_BLANK: begin
               if (phase == PH_W'(P_H_BLANK - 1)) begin
                  phase <= '0;
                  row   <= row + ROW_W'(1);
                  addr  <= addr + P_ADDR_WIDTH'(1);
                  rd_en <= 1'b1;
                  state <= LINE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            V_TAIL: begin
               if (phase == PH_W'(P_V_PORCH - 1)) begin
                  phase <= '0;
                  v_fsm <= 1'b0;
                  state <= V_BLANK;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            V_BLANK: begin
               if (phase == PH_W'(P_V_BLANK - 1)) begin
                  phase <= '0;
                  if (bus.i_continuous) begin
                     row   <= '0;
                     addr  <= '0;
                     v_fsm <= 1'b1;
                     state <= V_LEAD;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Two-stage output pipeline: stage 2 lines v/h up with the RAM data, which
   // arrives one cycle after the strobe; frame_done marks the v_sync falling edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         v_s1   <= 1'b0;
         h_s1   <= 1'b0;
         v_s2   <= 1'b0;
         h_s2   <= 1'b0;
         img_q  <= '0;
         done_q <= 1'b0;
      end else begin
         v_s1   <= v_fsm;
         h_s1   <= rd_en;
         v_s2   <= v_s1;
         h_s2   <= h_s1;
         img_q  <= h_s1 ? bus.i_rd_data : '0;
         done_q <= v_s2 & ~v_s1;
      end
   end

   assign bus.o_rd_en      = rd_en;
   assign bus.o_rd_addr    = addr;
   assign bus.o_v_sync     = v_s2;
   assign bus.o_h_sync     = h_s2;
   assign bus.o_img_data   = img_q;
   assign bus.o_busy       = busy;
   assign bus.o_frame_done = done_q;

endmodule
